// File: rtl/decode_stage_if.sv
// Fetch-to-execute decode bus: input valid/ready + instruction, flush, and the
// registered decoded fields, control flags and statistics counters.
interface decode_stage_if #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [4:0]         out_rs;
  logic [4:0]         out_rt;
  logic [4:0]         out_wreg;
  logic [4:0]         out_shamt;
  logic [31:0]        out_imm;
  logic [25:0]        out_jtarget;
  logic [ALUOP_W-1:0] out_alu_op;
  logic               out_alu_src_imm;
  logic               out_regwrite;
  logic               out_memread;
  logic               out_memwrite;
  logic               out_branch;
  logic               out_jump;
  logic               out_illegal;
  logic [CNT_W-1:0]   instr_cnt;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_rs, out_rt, out_wreg, out_shamt, out_imm,
           out_jtarget, out_alu_op, out_alu_src_imm, out_regwrite, out_memread,
           out_memwrite, out_branch, out_jump, out_illegal, instr_cnt, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_rs, out_rt, out_wreg, out_shamt, out_imm,
           out_jtarget, out_alu_op, out_alu_src_imm, out_regwrite, out_memread,
           out_memwrite, out_branch, out_jump, out_illegal, instr_cnt, stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS-subset decode stage: instruction fields and control into a valid/ready
// pipeline register, with load-use bubble insertion, flush and saturating counters.
module decode_stage #(
  parameter int unsigned ALUOP_W   = 4,
  parameter bit          HAZARD_EN = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(6);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sx;
  logic [31:0] imm_zx;
  logic [31:0] imm_hi;

  assign op     = bus.in_instr[31:26];
  assign fn     = bus.in_instr[5:0];
  assign rs     = bus.in_instr[25:21];
  assign rt     = bus.in_instr[20:16];
  assign rd     = bus.in_instr[15:11];
  assign imm_sx = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
  assign imm_zx = {16'h0000, bus.in_instr[15:0]};
  assign imm_hi = {bus.in_instr[15:0], 16'h0000};

  logic [ALUOP_W-1:0] d_alu;
  logic [31:0]        d_imm;
  logic [4:0]         d_wreg;
  logic               d_src_imm;
  logic               d_rw;
  logic               d_mr;
  logic               d_mw;
  logic               d_br;
  logic               d_jp;
  logic               d_ill;

  always_comb begin
    d_alu     = ALU_ADD;
    d_imm     = imm_sx;
    d_wreg    = '0;
    d_src_imm = 1'b0;
    d_rw      = 1'b0;
    d_mr      = 1'b0;
    d_mw      = 1'b0;
    d_br      = 1'b0;
    d_jp      = 1'b0;
    d_ill     = 1'b0;
    case (op)
      OP_RTYPE: begin
        d_wreg = rd;
        d_rw   = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU: d_alu = ALU_ADD;
          FN_SUB, FN_SUBU: d_alu = ALU_SUB;
          FN_AND:          d_alu = ALU_AND;
          FN_OR:           d_alu = ALU_OR;
          FN_SLT:          d_alu = ALU_SLT;
          FN_SLL:          d_alu = ALU_SLL;
          default: begin
            d_wreg = '0;
            d_rw   = 1'b0;
            d_ill  = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        d_src_imm = 1'b1;
        d_rw      = 1'b1;
        d_wreg    = rt;
      end
      OP_ANDI: begin
        d_alu     = ALU_AND;
        d_imm     = imm_zx;
        d_src_imm = 1'b1;
        d_rw      = 1'b1;
        d_wreg    = rt;
      end
      OP_ORI: begin
        d_alu     = ALU_OR;
        d_imm     = imm_zx;
        d_src_imm = 1'b1;
        d_rw      = 1'b1;
        d_wreg    = rt;
      end
      OP_LUI: begin
        d_alu     = ALU_LUI;
        d_imm     = imm_hi;
        d_src_imm = 1'b1;
        d_rw      = 1'b1;
        d_wreg    = rt;
      end
      OP_LW: begin
        d_src_imm = 1'b1;
        d_rw      = 1'b1;
        d_mr      = 1'b1;
        d_wreg    = rt;
      end
      OP_SW: begin
        d_src_imm = 1'b1;
        d_mw      = 1'b1;
      end
      OP_BEQ: begin
        d_alu = ALU_SUB;
        d_br  = 1'b1;
      end
      OP_J:    d_jp  = 1'b1;
      default: d_ill = 1'b1;
    endcase
    // Writes to $0 are dropped here so nop and rt=0 immediates never write back.
    if (d_wreg == '0) d_rw = 1'b0;
  end

  logic use_rs;
  logic use_rt;
  logic hazard;
  logic xfer_in;

  assign use_rs = !((op == OP_J) || (op == OP_LUI) || ((op == OP_RTYPE) && (fn == FN_SLL)));
  assign use_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);

  // Load still in the output register whose destination the incoming instruction reads.
  assign hazard = HAZARD_EN && bus.out_valid && bus.out_memread && (bus.out_wreg != '0) &&
                  ((use_rs && (bus.out_wreg == rs)) || (use_rt && (bus.out_wreg == rt)));

  assign bus.in_ready = !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
  assign xfer_in      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid       <= 1'b0;
      bus.out_rs          <= '0;
      bus.out_rt          <= '0;
      bus.out_wreg        <= '0;
      bus.out_shamt       <= '0;
      bus.out_imm         <= '0;
      bus.out_jtarget     <= '0;
      bus.out_alu_op      <= '0;
      bus.out_alu_src_imm <= 1'b0;
      bus.out_regwrite    <= 1'b0;
      bus.out_memread     <= 1'b0;
      bus.out_memwrite    <= 1'b0;
      bus.out_branch      <= 1'b0;
      bus.out_jump        <= 1'b0;
      bus.out_illegal     <= 1'b0;
      bus.instr_cnt       <= '0;
      bus.stall_cnt       <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (xfer_in) begin
      bus.out_valid       <= 1'b1;
      bus.out_rs          <= rs;
      bus.out_rt          <= rt;
      bus.out_wreg        <= d_wreg;
      bus.out_shamt       <= bus.in_instr[10:6];
      bus.out_imm         <= d_imm;
      bus.out_jtarget     <= bus.in_instr[25:0];
      bus.out_alu_op      <= d_alu;
      bus.out_alu_src_imm <= d_src_imm;
      bus.out_regwrite    <= d_rw;
      bus.out_memread     <= d_mr;
      bus.out_memwrite    <= d_mw;
      bus.out_branch      <= d_br;
      bus.out_jump        <= d_jp;
      bus.out_illegal     <= d_ill;
      if (bus.instr_cnt != '1) bus.instr_cnt <= bus.instr_cnt + 1'b1;
    end else if (hazard && bus.out_ready) begin
      bus.out_valid <= 1'b0;
      if (bus.stall_cnt != '1) bus.stall_cnt <= bus.stall_cnt + 1'b1;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: one interlocked and one non-interlocked instance driven
// identically, checked by vector table, directed sequences and a random reference model.
module tb_decode_stage;
  localparam int unsigned AW = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        tv    = 1'b0;
  logic        tf    = 1'b0;
  logic        tr    = 1'b0;
  logic [31:0] ti    = '0;

  always #5 clk = ~clk;

  decode_stage_if #(.ALUOP_W(AW), .CNT_W(6)) bh ();
  decode_stage_if #(.ALUOP_W(AW), .CNT_W(4)) bn ();

  assign bh.in_valid  = tv;
  assign bh.in_instr  = ti;
  assign bh.flush     = tf;
  assign bh.out_ready = tr;
  assign bn.in_valid  = tv;
  assign bn.in_instr  = ti;
  assign bn.flush     = tf;
  assign bn.out_ready = tr;

  decode_stage #(.ALUOP_W(AW), .HAZARD_EN(1'b1), .CNT_W(6)) u_hz (
    .clk(clk), .rst_n(rst_n), .bus(bh.slave));
  decode_stage #(.ALUOP_W(AW), .HAZARD_EN(1'b0), .CNT_W(4)) u_nohz (
    .clk(clk), .rst_n(rst_n), .bus(bn.slave));

  // fl = {alu_src_imm, regwrite, memread, memwrite, branch, jump, illegal}
  typedef struct {
    logic [4:0]    rs, rt, wreg, shamt;
    logic [31:0]   imm;
    logic [25:0]   jt;
    logic [AW-1:0] alu;
    logic [6:0]    fl;
    bit            imm_def, alu_def, jt_def;
  } dec_t;

  dec_t        od[2];
  logic        ov[2];
  logic        ordy[2];
  int unsigned oic[2];
  int unsigned osc[2];

  always_comb begin
    od[0].rs = bh.out_rs; od[0].rt = bh.out_rt; od[0].wreg = bh.out_wreg;
    od[0].shamt = bh.out_shamt; od[0].imm = bh.out_imm; od[0].jt = bh.out_jtarget;
    od[0].alu = bh.out_alu_op;
    od[0].fl = {bh.out_alu_src_imm, bh.out_regwrite, bh.out_memread, bh.out_memwrite,
                bh.out_branch, bh.out_jump, bh.out_illegal};
    od[0].imm_def = 1'b0; od[0].alu_def = 1'b0; od[0].jt_def = 1'b0;
    od[1].rs = bn.out_rs; od[1].rt = bn.out_rt; od[1].wreg = bn.out_wreg;
    od[1].shamt = bn.out_shamt; od[1].imm = bn.out_imm; od[1].jt = bn.out_jtarget;
    od[1].alu = bn.out_alu_op;
    od[1].fl = {bn.out_alu_src_imm, bn.out_regwrite, bn.out_memread, bn.out_memwrite,
                bn.out_branch, bn.out_jump, bn.out_illegal};
    od[1].imm_def = 1'b0; od[1].alu_def = 1'b0; od[1].jt_def = 1'b0;
    ov[0] = bh.out_valid;  ov[1] = bn.out_valid;
    ordy[0] = bh.in_ready; ordy[1] = bn.in_ready;
    oic[0] = 32'(bh.instr_cnt); oic[1] = 32'(bn.instr_cnt);
    osc[0] = 32'(bh.stall_cnt); osc[1] = 32'(bn.stall_cnt);
  end

  // Decode rules as lookup tables: R-type funct -> alu op, I-type opcode -> behaviour.
  typedef struct { logic [5:0] code; int alu; int ext; bit rw, mr, mw; } irow_t;
  irow_t itab[7] = '{'{6'h08, 0, 0, 1'b1, 1'b0, 1'b0}, '{6'h09, 0, 0, 1'b1, 1'b0, 1'b0},
                     '{6'h0C, 2, 1, 1'b1, 1'b0, 1'b0}, '{6'h0D, 3, 1, 1'b1, 1'b0, 1'b0},
                     '{6'h0F, 6, 2, 1'b1, 1'b0, 1'b0}, '{6'h23, 0, 0, 1'b1, 1'b1, 1'b0},
                     '{6'h2B, 0, 0, 1'b0, 1'b0, 1'b1}};
  logic [5:0] rfn[8]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00};
  int         ralu[8] = '{0, 0, 1, 1, 2, 3, 4, 5};

  function automatic dec_t ref_dec(input logic [31:0] x);
    dec_t d;
    bit found = 0, si = 0, rw = 0, mr = 0, mw = 0, br = 0, jp = 0;
    d.rs = x[25:21]; d.rt = x[20:16]; d.shamt = x[10:6]; d.jt = x[25:0];
    d.imm = {{16{x[15]}}, x[15:0]}; d.wreg = '0; d.alu = '0;
    d.imm_def = 1; d.alu_def = 1; d.jt_def = 0;
    if (x[31:26] == 6'h00) begin
      d.imm_def = 0;
      for (int k = 0; k < 8; k++)
        if (x[5:0] == rfn[k]) begin
          found = 1; rw = 1; d.wreg = x[15:11]; d.alu = AW'(ralu[k]);
        end
    end else if (x[31:26] == 6'h04) begin
      found = 1; br = 1; d.alu = AW'(1);
    end else if (x[31:26] == 6'h02) begin
      found = 1; jp = 1; d.jt_def = 1; d.alu_def = 0; d.imm_def = 0;
    end else begin
      for (int k = 0; k < 7; k++)
        if (x[31:26] == itab[k].code) begin
          found = 1; si = 1; rw = itab[k].rw; mr = itab[k].mr; mw = itab[k].mw;
          d.alu = AW'(itab[k].alu);
          d.wreg = mw ? 5'd0 : x[20:16];
          if (itab[k].ext == 1) d.imm = {16'h0, x[15:0]};
          if (itab[k].ext == 2) d.imm = {x[15:0], 16'h0};
        end
    end
    if (d.wreg == 0) rw = 0;
    d.fl = {si, rw, mr, mw, br, jp, !found};
    if (!found) begin
      d.wreg = '0; d.alu_def = 0; d.imm_def = 0;
    end
    return d;
  endfunction

  function automatic bit uses_rs(input logic [31:0] x);
    return !(x[31:26] == 6'h02 || x[31:26] == 6'h0F || (x[31:26] == 6'h00 && x[5:0] == 6'h00));
  endfunction

  function automatic bit uses_rt(input logic [31:0] x);
    return x[31:26] == 6'h00 || x[31:26] == 6'h04 || x[31:26] == 6'h2B;
  endfunction

  bit          mv[2];
  dec_t        md[2];
  int unsigned mic[2];
  int unsigned msc[2];
  int unsigned cmax[2] = '{63, 15};
  bit          hen[2]  = '{1'b1, 1'b0};

  function automatic bit hazard_of(input int i, input logic [31:0] x);
    return hen[i] && mv[i] && md[i].fl[4] && md[i].wreg != 0 &&
           ((uses_rs(x) && md[i].wreg == x[25:21]) || (uses_rt(x) && md[i].wreg == x[20:16]));
  endfunction

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  task automatic compare_out(input int i);
    check($sformatf("valid[%0d]", i), ov[i], mv[i]);
    check($sformatf("instr_cnt[%0d]", i), oic[i], mic[i]);
    check($sformatf("stall_cnt[%0d]", i), osc[i], msc[i]);
    if (mv[i]) begin
      check($sformatf("fields[%0d]", i), {od[i].rs, od[i].rt, od[i].wreg, od[i].shamt, od[i].fl},
            {md[i].rs, md[i].rt, md[i].wreg, md[i].shamt, md[i].fl});
      if (md[i].alu_def) check($sformatf("alu_op[%0d]", i), od[i].alu, md[i].alu);
      if (md[i].imm_def) check($sformatf("imm[%0d]", i), od[i].imm, md[i].imm);
      if (md[i].jt_def)  check($sformatf("jtarget[%0d]", i), od[i].jt, md[i].jt);
    end
  endtask

  // Called at a negedge with inputs applied; advances one clock and the model with it.
  task automatic tick();
    bit nv[2]; dec_t nd[2]; int unsigned nic[2], nsc[2]; bit hz, rdy;
    #1;
    for (int i = 0; i < 2; i++) begin
      hz  = hazard_of(i, ti);
      rdy = !tf && !hz && (!mv[i] || tr);
      check($sformatf("in_ready[%0d]", i), ordy[i], rdy);
      nv[i] = mv[i]; nd[i] = md[i]; nic[i] = mic[i]; nsc[i] = msc[i];
      if (tf) nv[i] = 0;
      else if (tv && rdy) begin
        nv[i] = 1; nd[i] = ref_dec(ti);
        if (nic[i] < cmax[i]) nic[i]++;
      end else if (hz && tr) begin
        nv[i] = 0;
        if (nsc[i] < cmax[i]) nsc[i]++;
      end else if (mv[i] && tr) nv[i] = 0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mv[i] = nv[i]; md[i] = nd[i]; mic[i] = nic[i]; msc[i] = nsc[i];
      compare_out(i);
    end
    @(negedge clk);
  endtask

  task automatic reset_model_and_check();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mic[i] = 0; msc[i] = 0; md[i] = ref_dec(32'h0);
      check($sformatf("rst_valid[%0d]", i), ov[i], 0);
      check($sformatf("rst_ready[%0d]", i), ordy[i], 1);
      check($sformatf("rst_cnts[%0d]", i), {oic[i], osc[i]}, 0);
      check($sformatf("rst_fields[%0d]", i),
            {od[i].rs, od[i].rt, od[i].wreg, od[i].shamt, od[i].fl, od[i].alu}, 0);
      check($sformatf("rst_imm_jt[%0d]", i), {od[i].imm, od[i].jt}, 0);
    end
  endtask

  task automatic do_reset();
    tv = 0; tf = 0; tr = 0; ti = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 reset_model_and_check();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a = 5'($urandom_range(0, 3));
    logic [4:0] b = 5'($urandom_range(0, 3));
    logic [4:0] c = 5'($urandom_range(0, 3));
    logic [15:0] im = 16'($urandom);
    logic [5:0] iops[4] = '{6'h08, 6'h0C, 6'h0D, 6'h0F};
    case ($urandom_range(0, 11))
      0, 1, 2, 3: return {6'h23, a, b, im};
      4: return {6'h00, a, b, c, 5'($urandom), rfn[$urandom_range(0, 7)]};
      5: return {6'h00, a, b, c, 5'($urandom), 6'($urandom)};
      6: return {6'h2B, a, b, im};
      7: return {6'h04, a, b, im};
      8: return {iops[$urandom_range(0, 3)], a, b, im};
      9: return {6'h02, 26'($urandom)};
      10: return {6'h3F - 6'($urandom_range(0, 3)), a, b, im};
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [31:0]   instr;
    logic [4:0]    wreg;
    logic [6:0]    fl;
    logic [AW-1:0] alu;
    logic [31:0]   imm;
    bit            chk_alu;
    bit            chk_imm;
  } vec_t;

  vec_t vt[20];

  initial begin
    vt[0]  = '{32'h012A4020, 5'd8, 7'b0100000, 4'd0, 32'h0,        1, 0};
    vt[1]  = '{32'h00221822, 5'd3, 7'b0100000, 4'd1, 32'h0,        1, 0};
    vt[2]  = '{32'h00C72824, 5'd5, 7'b0100000, 4'd2, 32'h0,        1, 0};
    vt[3]  = '{32'h00222025, 5'd4, 7'b0100000, 4'd3, 32'h0,        1, 0};
    vt[4]  = '{32'h0022482A, 5'd9, 7'b0100000, 4'd4, 32'h0,        1, 0};
    vt[5]  = '{32'h00031100, 5'd2, 7'b0100000, 4'd5, 32'h0,        1, 0};
    vt[6]  = '{32'h2002FFFF, 5'd2, 7'b1100000, 4'd0, 32'hFFFFFFFF, 1, 1};
    vt[7]  = '{32'h30238001, 5'd3, 7'b1100000, 4'd2, 32'h00008001, 1, 1};
    vt[8]  = '{32'h3402FFFF, 5'd2, 7'b1100000, 4'd3, 32'h0000FFFF, 1, 1};
    vt[9]  = '{32'h3C021234, 5'd2, 7'b1100000, 4'd6, 32'h12340000, 1, 1};
    vt[10] = '{32'h8D280004, 5'd8, 7'b1110000, 4'd0, 32'h00000004, 1, 1};
    vt[11] = '{32'hAD28FFFC, 5'd0, 7'b1001000, 4'd0, 32'hFFFFFFFC, 1, 1};
    vt[12] = '{32'h1022FFFE, 5'd0, 7'b0000100, 4'd1, 32'hFFFFFFFE, 1, 1};
    vt[13] = '{32'h08123456, 5'd0, 7'b0000010, 4'd0, 32'h0,        0, 0};
    vt[14] = '{32'hFC000000, 5'd0, 7'b0000001, 4'd0, 32'h0,        0, 0};
    vt[15] = '{32'h00000000, 5'd0, 7'b0000000, 4'd5, 32'h0,        1, 0};
    vt[16] = '{32'h00221830, 5'd0, 7'b0000001, 4'd0, 32'h0,        0, 0};
    vt[17] = '{32'h20000005, 5'd0, 7'b1000000, 4'd0, 32'h00000005, 1, 1};
    vt[18] = '{32'h24430010, 5'd3, 7'b1100000, 4'd0, 32'h00000010, 1, 1};
    vt[19] = '{32'h00221823, 5'd3, 7'b0100000, 4'd1, 32'h0,        1, 0};

    // Vector table: one instruction at a time, drained between entries.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      tv = 1; tr = 1; ti = vt[k].instr;
      tick();
      check($sformatf("vec%0d_wreg", k), od[0].wreg, vt[k].wreg);
      check($sformatf("vec%0d_flags", k), od[0].fl, vt[k].fl);
      check($sformatf("vec%0d_rs_rt", k), {od[0].rs, od[0].rt}, {vt[k].instr[25:21], vt[k].instr[20:16]});
      if (vt[k].chk_alu) check($sformatf("vec%0d_alu", k), od[0].alu, vt[k].alu);
      if (vt[k].chk_imm) check($sformatf("vec%0d_imm", k), od[0].imm, vt[k].imm);
      if (vt[k].fl[1])   check($sformatf("vec%0d_jt", k), od[0].jt, vt[k].instr[25:0]);
      check($sformatf("vec%0d_icnt", k), oic[0], k + 1);
      tv = 0;
      tick();
    end

    // Load-use pair: bubble on the interlocked instance only.
    do_reset();
    tv = 1; tr = 1; ti = 32'h8D280004;
    tick();
    check("lw_valid", ov[0], 1);
    ti = 32'h010B5020;
    #1;
    check("lu_in_ready_hz", ordy[0], 0);
    check("lu_in_ready_nohz", ordy[1], 1);
    tick();
    check("bubble_valid", ov[0], 0);
    check("bubble_stall_cnt", osc[0], 1);
    check("nohz_add_valid", ov[1], 1);
    check("nohz_stall_cnt", osc[1], 0);
    tick();
    check("stalled_add_valid", ov[0], 1);
    check("stalled_add_wreg", od[0].wreg, 10);
    check("stalled_add_icnt", oic[0], 2);
    tv = 0;
    tick();

    // Asynchronous reset while stalled clears the pending bubble.
    tv = 1; ti = 32'h8D280004;
    tick();
    ti = 32'h010B5020;
    #1;
    check("pre_rst_ready", ordy[0], 0);
    #1 rst_n = 1'b0;
    #1 reset_model_and_check();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_icnt", oic[0], 1);
    check("post_rst_stall", osc[0], 0);

    // Downstream backpressure holds the output register.
    do_reset();
    tv = 1; tr = 0; ti = 32'h2002FFFF;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_in_ready", ordy[0], 0);
      tick();
      check("hold_imm", od[0].imm, 32'hFFFFFFFF);
      check("hold_valid", ov[0], 1);
    end
    tr = 1; tv = 0;
    tick();
    check("hold_release_valid", ov[0], 0);
    check("hold_release_icnt", oic[0], 1);

    // Illegal, nop, then flush.
    do_reset();
    tv = 1; tr = 1; ti = 32'hFC000000;
    tick();
    check("ill_flag", od[0].fl[0], 1);
    check("ill_ctrl", od[0].fl[6:1], 0);
    ti = 32'h0;
    tick();
    check("nop_regwrite", od[0].fl[5], 0);
    check("nop_valid", ov[0], 1);
    tf = 1; ti = 32'h012A4020;
    #1;
    check("flush_in_ready", ordy[0], 0);
    tick();
    check("flush_valid", ov[0], 0);
    check("flush_icnt", oic[0], 2);
    tf = 0; tv = 0;
    tick();

    // Random traffic against the reference model, long enough to saturate counters.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tv = ($urandom_range(0, 9) < 8);
      tr = ($urandom_range(0, 3) != 0);
      tf = ($urandom_range(0, 24) == 0);
      ti = rand_instr();
      tick();
    end
    check("sat_icnt_hz", oic[0], 63);
    check("sat_icnt_nohz", oic[1], 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
